// File: rtl/eager_fork_buffer.sv
// Two-entry elastic buffer feeding an eager fork: each enabled destination takes
// the head word independently, and the word retires once all of them have it.
module eager_fork_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_OUTPUTS = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic [NUM_OUTPUTS-1:0] fork_mask_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [NUM_OUTPUTS-1:0] valids_o,
    input  logic [NUM_OUTPUTS-1:0] readys_i
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   head;
    logic [DATA_WIDTH-1:0]   skid;
    logic [NUM_OUTPUTS-1:0]  sent;
    logic [NUM_OUTPUTS-1:0]  sent_next;
    logic [NUM_OUTPUTS-1:0]  done;
    logic                    head_valid;
    logic                    all_done;
    logic                    acc;
    logic                    ret;
    logic                    load_head_in;
    logic                    load_head_skid;
    logic                    load_skid;

    // ready_o comes straight from the state register, so readys_i never reaches it combinationally
    assign head_valid = (state != EMPTY);
    assign ready_o    = (state != FULL);
    assign acc        = valid_i && ready_o;
    assign done       = ~fork_mask_i | sent | readys_i;
    assign all_done   = &done;
    assign ret        = head_valid && all_done;
    assign valids_o   = {NUM_OUTPUTS{head_valid}} & fork_mask_i & ~sent;
    assign data_o     = head;

    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_next   = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && ret) begin
                    load_head_in = 1'b1;
                end else if (acc) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (ret) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (ret) begin
                    state_next     = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        sent_next = ret ? '0 : (sent | (valids_o & readys_i));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
            sent  <= '0;
        end else if (clr_i) begin
            state <= EMPTY;
            sent  <= '0;
        end else begin
            state <= state_next;
            sent  <= sent_next;
        end
    end

    // Data registers stay at their last value when not loaded, so data_o holds after retire
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head <= '0;
            skid <= '0;
        end else if (clr_i) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_in) begin
                head <= data_i;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= data_i;
            end
        end
    end

endmodule
